// File: rtl/btb_update_unit.sv
// Execute-stage branch resolution: detects mispredicts, drives a registered flush/redirect,
// trains the BTB through its single write port and keeps branch/mispredict counters.
module btb_update_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int BTB_ROWS   = 16,
  localparam int IDX_W     = $clog2(BTB_ROWS),
  localparam int TAG_W     = DATA_WIDTH - IDX_W - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_stall,
  input  logic                  ex_is_branch,
  input  logic                  ex_is_jump,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic                  ex_taken,
  input  logic [DATA_WIDTH-1:0] ex_target,
  input  logic                  ex_pred_taken,
  input  logic [DATA_WIDTH-1:0] ex_pred_target,
  input  logic                  ex_btb_hit,
  input  logic [1:0]            ex_btb_pred,
  output logic                  flush,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  btb_we,
  output logic [IDX_W-1:0]      btb_index,
  output logic [TAG_W-1:0]      btb_tag,
  output logic [DATA_WIDTH-1:0] btb_target,
  output logic [1:0]            btb_pred,
  output logic                  btb_type,
  output logic [31:0]           perf_branches,
  output logic [31:0]           perf_mispredicts
);

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic                  act_taken_p0;
  logic                  resolve_p0;
  logic                  mispredict_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic [TAG_W-1:0]      tag_p0;
  logic                  fwd_hit_p0;
  logic [1:0]            ctr_p0;
  logic                  we_p0;
  logic [1:0]            pred_p0;
  logic                  type_p0;
  logic [DATA_WIDTH-1:0] target_p0;
  logic [DATA_WIDTH-1:0] redirect_p0;

  // Stage p0: resolve the EX instruction and form the BTB write
  always_comb begin
    act_taken_p0  = ex_is_jump | ex_taken;
    // The cycle after a mispredict, EX holds a wrong-path instruction: ignore it.
    resolve_p0    = ex_valid & ~ex_stall & ~flush & (ex_is_branch | ex_is_jump);
    mispredict_p0 = resolve_p0 & ((act_taken_p0 != ex_pred_taken) |
                                  (act_taken_p0 & (ex_pred_target != ex_target)));
    redirect_p0   = act_taken_p0 ? ex_target : ex_pc + DATA_WIDTH'(4);
    idx_p0        = ex_pc[IDX_W+1:2];
    tag_p0        = ex_pc[DATA_WIDTH-1:IDX_W+2];
    // The write issued last cycle is newer than the counter fetch read for this PC.
    fwd_hit_p0    = btb_we & (btb_index == idx_p0) & (btb_tag == tag_p0);
    ctr_p0        = fwd_hit_p0 ? btb_pred : ex_btb_pred;

    we_p0     = 1'b0;
    pred_p0   = 2'b00;
    type_p0   = 1'b0;
    target_p0 = ex_target;
    if (resolve_p0) begin
      if (ex_is_jump) begin
        we_p0   = 1'b1;
        pred_p0 = 2'b11;
        type_p0 = 1'b1;
      end else if (ex_btb_hit) begin
        we_p0     = 1'b1;
        pred_p0   = ex_taken ? sat_inc2(ctr_p0) : sat_dec2(ctr_p0);
        target_p0 = ex_taken ? ex_target : ex_pred_target;
      end else if (ex_taken) begin
        we_p0   = 1'b1;
        pred_p0 = 2'b10;
      end
    end
  end

  // Stage p1: registered flush/redirect, BTB write port and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      flush            <= 1'b0;
      redirect_pc      <= '0;
      btb_we           <= 1'b0;
      btb_index        <= '0;
      btb_tag          <= '0;
      btb_target       <= '0;
      btb_pred         <= 2'b00;
      btb_type         <= 1'b0;
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      flush  <= mispredict_p0;
      btb_we <= we_p0;
      if (mispredict_p0) redirect_pc <= redirect_p0;
      if (we_p0) begin
        btb_index  <= idx_p0;
        btb_tag    <= tag_p0;
        btb_target <= target_p0;
        btb_pred   <= pred_p0;
        btb_type   <= type_p0;
      end
      perf_branches    <= sat_inc32(perf_branches, resolve_p0);
      perf_mispredicts <= sat_inc32(perf_mispredicts, mispredict_p0);
    end
  end

endmodule

// File: tb/tb_btb_update_unit.sv
// Bench for btb_update_unit: directed scenarios plus randomized traffic against a reference model.
module tb_btb_update_unit;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid, ex_stall, ex_is_branch, ex_is_jump;
  logic [DW-1:0] ex_pc, ex_target, ex_pred_target;
  logic          ex_taken, ex_pred_taken, ex_btb_hit;
  logic [1:0]    ex_btb_pred;
  logic          flush, btb_we, btb_type;
  logic [DW-1:0] redirect_pc, btb_target;
  logic [3:0]    btb_index;
  logic [25:0]   btb_tag;
  logic [1:0]    btb_pred;
  logic [31:0]   perf_branches, perf_mispredicts;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs must show after the next edge
  logic          m_flush, m_we, m_type;
  logic [DW-1:0] m_redirect, m_target;
  logic [29:0]   m_wpc;
  logic [1:0]    m_pred;
  longint        m_pb, m_pm;

  btb_update_unit #(.DATA_WIDTH(32), .BTB_ROWS(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_btb_hit(ex_btb_hit), .ex_btb_pred(ex_btb_pred),
    .flush(flush), .redirect_pc(redirect_pc), .btb_we(btb_we), .btb_index(btb_index),
    .btb_tag(btb_tag), .btb_target(btb_target), .btb_pred(btb_pred), .btb_type(btb_type),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic clr_in();
    ex_valid = 0; ex_stall = 0; ex_is_branch = 0; ex_is_jump = 0; ex_pc = 0;
    ex_taken = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    ex_btb_hit = 0; ex_btb_pred = 0;
  endtask

  task automatic set_br(input logic [DW-1:0] pc, input logic tk, input logic [DW-1:0] tgt,
                        input logic pt, input logic [DW-1:0] ptgt, input logic hit,
                        input logic [1:0] bp, input logic jmp);
    ex_valid = 1; ex_stall = 0; ex_is_branch = ~jmp; ex_is_jump = jmp; ex_pc = pc;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    ex_btb_hit = hit; ex_btb_pred = bp;
  endtask

  // Model advances from the inputs present before the edge, then the edge happens.
  task automatic tick();
    logic res, act, mis, wr, nty;
    logic [1:0] np;
    logic [DW-1:0] nt;
    int c;
    if (rst) begin
      m_flush = 0; m_we = 0; m_type = 0; m_redirect = 0; m_target = 0;
      m_wpc = 0; m_pred = 0; m_pb = 0; m_pm = 0;
    end else begin
      res = ex_valid && !ex_stall && !m_flush && (ex_is_branch || ex_is_jump);
      act = ex_is_jump || ex_taken;
      mis = res && ((act != ex_pred_taken) || (act && ex_pred_target != ex_target));
      wr = 0; np = 0; nt = 0; nty = 0;
      if (res) begin
        if (ex_is_jump) begin
          wr = 1; np = 3; nty = 1; nt = ex_target;
        end else if (ex_btb_hit) begin
          c = (m_we && m_wpc == ex_pc[31:2]) ? int'(m_pred) : int'(ex_btb_pred);
          c = ex_taken ? c + 1 : c - 1;
          if (c > 3) c = 3;
          if (c < 0) c = 0;
          wr = 1; np = 2'(c); nt = ex_taken ? ex_target : ex_pred_target;
        end else if (ex_taken) begin
          wr = 1; np = 2; nt = ex_target;
        end
      end
      if (res && m_pb < 64'hFFFF_FFFF) m_pb++;
      if (mis && m_pm < 64'hFFFF_FFFF) m_pm++;
      m_flush = mis;
      if (mis) m_redirect = act ? ex_target : ex_pc + 32'd4;
      m_we = wr;
      if (wr) begin m_wpc = ex_pc[31:2]; m_pred = np; m_target = nt; m_type = nty; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_in(); rst = 1; tick(); tick(); rst = 0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%0b exp=0", flush); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got=%h exp=0", redirect_pc); end
    checks++; if (btb_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", btb_we); end
    checks++; if ({btb_index, btb_tag, btb_target, btb_pred, btb_type} !== '0) begin
      errors++; $display("FAIL reset_btb_fields got=%h/%h/%h/%b/%b exp=0", btb_index, btb_tag, btb_target, btb_pred, btb_type); end
    checks++; if (perf_branches !== 32'h0 || perf_mispredicts !== 32'h0) begin
      errors++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_branches, perf_mispredicts); end
  endtask

  task automatic test_miss_taken();
    set_br(32'h100, 1, 32'h180, 0, 32'h0, 0, 2'b00, 0); tick();
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL miss_flush got=%0b exp=1", flush); end
    checks++; if (redirect_pc !== 32'h180) begin errors++; $display("FAIL miss_redirect got=%h exp=180", redirect_pc); end
    checks++; if (btb_we !== 1'b1 || btb_index !== 4'h0 || btb_tag !== 26'h4) begin
      errors++; $display("FAIL miss_write got we=%0b idx=%h tag=%h exp we=1 idx=0 tag=4", btb_we, btb_index, btb_tag); end
    checks++; if (btb_pred !== 2'b10 || btb_type !== 1'b0 || btb_target !== 32'h180) begin
      errors++; $display("FAIL miss_entry got pred=%b type=%b tgt=%h exp 10/0/180", btb_pred, btb_type, btb_target); end
    checks++; if (perf_mispredicts !== 32'd1) begin errors++; $display("FAIL miss_perf got=%0d exp=1", perf_mispredicts); end
    clr_in(); tick();
  endtask

  task automatic test_hit_not_taken();
    logic [31:0] pb0;
    set_br(32'h104, 0, 32'h150, 1, 32'h150, 1, 2'b10, 0); tick();
    pb0 = perf_branches;
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h108) begin
      errors++; $display("FAIL hnt_redirect got flush=%0b pc=%h exp 1/108", flush, redirect_pc); end
    checks++; if (btb_we !== 1'b1 || btb_pred !== 2'b01 || btb_target !== 32'h150) begin
      errors++; $display("FAIL hnt_write got we=%0b pred=%b tgt=%h exp 1/01/150", btb_we, btb_pred, btb_target); end
    set_br(32'h10c, 1, 32'h500, 0, 32'h0, 0, 2'b00, 0); tick();
    checks++; if (flush !== 1'b0 || btb_we !== 1'b0) begin
      errors++; $display("FAIL wrong_path got flush=%0b we=%0b exp 0/0", flush, btb_we); end
    checks++; if (perf_branches !== pb0) begin errors++; $display("FAIL wrong_path_perf got=%0d exp=%0d", perf_branches, pb0); end
    clr_in(); tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_seq [3] = '{2'b10, 2'b11, 2'b11};
    set_br(32'h200, 1, 32'h280, 1, 32'h280, 1, 2'b01, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (btb_we !== 1'b1 || btb_pred !== exp_seq[i] || flush !== 1'b0) begin
        errors++; $display("FAIL b2b_%0d got we=%0b pred=%b flush=%0b exp 1/%b/0", i, btb_we, btb_pred, flush, exp_seq[i]); end
    end
    clr_in(); tick();
  endtask

  task automatic test_jump_stall();
    logic [31:0] pb0;
    pb0 = perf_branches;
    set_br(32'h40, 0, 32'h300, 0, 32'h0, 0, 2'b00, 1);
    ex_stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (btb_we !== 1'b0 || flush !== 1'b0 || perf_branches !== pb0) begin
        errors++; $display("FAIL stall_%0d got we=%0b flush=%0b pb=%0d exp 0/0/%0d", i, btb_we, flush, perf_branches, pb0); end
    end
    ex_stall = 0; tick();
    checks++; if (btb_we !== 1'b1 || btb_type !== 1'b1 || btb_pred !== 2'b11 || btb_target !== 32'h300) begin
      errors++; $display("FAIL jump_write got we=%0b type=%b pred=%b tgt=%h exp 1/1/11/300", btb_we, btb_type, btb_pred, btb_target); end
    checks++; if (flush !== 1'b1 || redirect_pc !== 32'h300) begin
      errors++; $display("FAIL jump_redirect got flush=%0b pc=%h exp 1/300", flush, redirect_pc); end
    tick();
    checks++; if (btb_we !== 1'b0 || perf_branches !== pb0 + 32'd1) begin
      errors++; $display("FAIL jump_single got we=%0b pb=%0d exp 0/%0d", btb_we, perf_branches, pb0 + 32'd1); end
    clr_in(); tick();
  endtask

  task automatic test_reset_mid();
    set_br(32'h100, 1, 32'h180, 0, 32'h0, 0, 2'b00, 0); tick();
    set_br(32'h120, 1, 32'h1c0, 0, 32'h0, 0, 2'b00, 0); rst = 1; tick(); rst = 0;
    checks++; if (flush !== 1'b0 || btb_we !== 1'b0) begin
      errors++; $display("FAIL rst_mid got flush=%0b we=%0b exp 0/0", flush, btb_we); end
    checks++; if (perf_branches !== 32'h0 || perf_mispredicts !== 32'h0) begin
      errors++; $display("FAIL rst_mid_perf got=%0d/%0d exp=0/0", perf_branches, perf_mispredicts); end
    clr_in(); tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] pcs [4] = '{32'h200, 32'h204, 32'h208, 32'h1200};
    logic [DW-1:0] tgts [2] = '{32'h400, 32'h480};
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_br(pcs[$urandom_range(0, 3)], 1'($urandom), tgts[$urandom_range(0, 1)],
             1'($urandom), tgts[$urandom_range(0, 1)], 1'($urandom), 2'($urandom),
             ($urandom_range(0, 5) == 0));
      ex_valid = ($urandom_range(0, 7) != 0);
      ex_stall = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) ex_is_branch = 1;
      tick();
      checks++; if (flush !== m_flush || btb_we !== m_we) begin
        errors++; $display("FAIL rnd_ctl[%0d] got flush=%0b we=%0b exp %0b/%0b", i, flush, btb_we, m_flush, m_we); end
      checks++; if (perf_branches !== 32'(m_pb) || perf_mispredicts !== 32'(m_pm)) begin
        errors++; $display("FAIL rnd_perf[%0d] got=%0d/%0d exp=%0d/%0d", i, perf_branches, perf_mispredicts, m_pb, m_pm); end
      if (m_flush) begin
        checks++; if (redirect_pc !== m_redirect) begin
          errors++; $display("FAIL rnd_redirect[%0d] got=%h exp=%h", i, redirect_pc, m_redirect); end
      end
      if (m_we) begin
        checks++; if (btb_index !== m_wpc[3:0] || btb_tag !== m_wpc[29:4] || btb_target !== m_target ||
                      btb_pred !== m_pred || btb_type !== m_type) begin
          errors++; $display("FAIL rnd_write[%0d] got %h/%h/%h/%b/%b exp %h/%h/%h/%b/%b", i, btb_index, btb_tag,
                             btb_target, btb_pred, btb_type, m_wpc[3:0], m_wpc[29:4], m_target, m_pred, m_type); end
      end
    end
    rst = 0; clr_in(); tick();
  endtask

  initial begin
    rst = 1;
    clr_in();
    test_reset();
    test_miss_taken();
    test_hit_not_taken();
    test_back_to_back();
    test_jump_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
